raddr_engine: RTL and testbench

RADDR_ENGINE -- requirements
Module: raddr_engine

---
 rtl/raddr_engine_if.sv | 12 +
 rtl/raddr_engine.sv | 167 ++++++++++++++++
 tb/tb_raddr_engine.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/raddr_engine_if.sv
// AXI read-address channel bundle used between the address engine and the fabric.
interface raddr_engine_if #(
  parameter int unsigned ADDR_W = 64
) ();
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic              arvalid;
  logic              arready;

  modport master (output araddr, arlen, arvalid, input arready);
  modport slave  (input araddr, arlen, arvalid, output arready);
endinterface

// File: rtl/raddr_engine.sv
// Read-address engine: optional header burst, then raster-order macroblock bursts,
// limited by an outstanding-burst window; pulses done once all bursts have drained.
module raddr_engine #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DIM_W     = 10,
  parameter int unsigned MB_STRIDE = 384,
  parameter int unsigned MB_LEN    = 2,
  parameter int unsigned HDR_LEN   = 5,
  parameter int unsigned MAX_OUT   = 4
) (
  input  logic                clk,
  input  logic                rst,
  raddr_engine_if.master      m_axi,
  input  logic                rd_last_beat,
  input  logic                start_pulse,
  input  logic                hdr_en,
  input  logic [ADDR_W-1:0]   hdr_address,
  input  logic [ADDR_W-1:0]   source_address,
  input  logic [ADDR_W-1:0]   row_stride,
  input  logic [DIM_W-1:0]    w1,
  input  logic [DIM_W-1:0]    h1,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE, HDR, MB, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [DIM_W-1:0]   x_q, x_d, y_q, y_d, w1_q, w1_d, h1_q, h1_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d, addr_q, addr_d;
  logic [ADDR_W-1:0]  hdr_addr_q, hdr_addr_d, stride_q, stride_d;
  logic [ADDR_W-1:0]  araddr_q, araddr_d;
  logic [7:0]         arlen_q, arlen_d;
  logic               arvalid_q, arvalid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               hs, dec, can_issue;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w1_q       <= '0;
      h1_q       <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      hdr_addr_q <= '0;
      stride_q   <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arvalid_q  <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w1_q       <= w1_d;
      h1_q       <= h1_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      hdr_addr_q <= hdr_addr_d;
      stride_q   <= stride_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arvalid_q  <= arvalid_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w1_d       = w1_q;
    h1_d       = h1_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    hdr_addr_d = hdr_addr_q;
    stride_d   = stride_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arvalid_d  = arvalid_q;
    done_d     = 1'b0;

    hs        = arvalid_q & m_axi.arready;
    dec       = rd_last_beat & (cnt_q != '0);
    can_issue = ~arvalid_q & (cnt_q < CNT_W'(MAX_OUT));

    cnt_d = cnt_q;
    if (hs & ~dec)      cnt_d = cnt_q + CNT_W'(1);
    else if (~hs & dec) cnt_d = cnt_q - CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (start_pulse) begin
          hdr_addr_d = hdr_address;
          stride_d   = row_stride;
          w1_d       = w1;
          h1_d       = h1;
          x_d        = '0;
          y_d        = '0;
          row_base_d = source_address;
          addr_d     = source_address;
          state_d    = hdr_en ? HDR : MB;
        end
      end
      HDR: begin
        if (hs) begin
          arvalid_d = 1'b0;
          state_d   = MB;
        end else if (can_issue) begin
          arvalid_d = 1'b1;
          araddr_d  = hdr_addr_q;
          arlen_d   = 8'(HDR_LEN);
        end
      end
      MB: begin
        if (hs) begin
          arvalid_d = 1'b0;
          if (x_q == w1_q) begin
            if (y_q == h1_q) begin
              state_d = DRAIN;
            end else begin
              // Next row starts from the row base, not from the running column address
              x_d        = '0;
              y_d        = y_q + DIM_W'(1);
              row_base_d = row_base_q + stride_q;
              addr_d     = row_base_q + stride_q;
            end
          end else begin
            x_d    = x_q + DIM_W'(1);
            addr_d = addr_q + ADDR_W'(MB_STRIDE);
          end
        end else if (can_issue) begin
          arvalid_d = 1'b1;
          araddr_d  = addr_q;
          arlen_d   = 8'(MB_LEN);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign m_axi.araddr  = araddr_q;
  assign m_axi.arlen   = arlen_q;
  assign m_axi.arvalid = arvalid_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_raddr_engine.sv
// Directed bench for raddr_engine: table of frame configurations plus hand-written
// sequences for stalls, outstanding limit, simultaneous events and mid-frame reset.
module tb_raddr_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_pulse = 1'b0;
  logic        hdr_en = 1'b0;
  logic [63:0] hdr_address = '0, source_address = '0, row_stride = '0;
  logic [9:0]  w1 = '0, h1 = '0;
  logic        busy, done;
  logic        rd_last_beat;
  logic        rsp_pulse = 1'b0;
  logic        man_rd = 1'b0;
  bit          auto_rsp = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  raddr_engine_if #(.ADDR_W(64)) m_axi ();

  assign rd_last_beat = rsp_pulse | man_rd;

  raddr_engine #(.ADDR_W(64), .DIM_W(10), .MB_STRIDE(384), .MB_LEN(2), .HDR_LEN(5), .MAX_OUT(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .m_axi          (m_axi),
    .rd_last_beat   (rd_last_beat),
    .start_pulse    (start_pulse),
    .hdr_en         (hdr_en),
    .hdr_address    (hdr_address),
    .source_address (source_address),
    .row_stride     (row_stride),
    .w1             (w1),
    .h1             (h1),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake log and delayed rd_last_beat responder, evaluated between edges
  logic [63:0] log_a [256];
  logic [7:0]  log_l [256];
  int          hs_n = 0;
  int          due [$];

  always @(negedge clk) begin
    rsp_pulse = 1'b0;
    if (rst) begin
      due.delete();
    end else begin
      if (due.size() > 0 && due[0] <= cyc) begin
        rsp_pulse = 1'b1;
        void'(due.pop_front());
      end
      if (m_axi.arvalid && m_axi.arready) begin
        if (hs_n < 256) begin
          log_a[hs_n] = m_axi.araddr;
          log_l[hs_n] = m_axi.arlen;
        end
        hs_n = hs_n + 1;
        if (auto_rsp) due.push_back(cyc + 2);
      end
    end
  end

  typedef struct {
    logic        hdr_en;
    logic [63:0] hdr_a;
    logic [63:0] src;
    logic [63:0] stride;
    logic [9:0]  w1;
    logic [9:0]  h1;
    int          n;
    int          first;
  } frame_t;

  frame_t      f [8];
  frame_t      alt;
  logic [63:0] exp_a [32];
  logic [7:0]  exp_l [32];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_exp(input int i, input logic [63:0] a, input logic [7:0] l);
    exp_a[i] = a;
    exp_l[i] = l;
  endtask

  task automatic start_frame(input frame_t c);
    hdr_en         = c.hdr_en;
    hdr_address    = c.hdr_a;
    source_address = c.src;
    row_stride     = c.stride;
    w1             = c.w1;
    h1             = c.h1;
    start_pulse    = 1'b1;
    step();
    start_pulse    = 1'b0;
  endtask

  task automatic wait_arvalid(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (m_axi.arvalid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: arvalid timeout got 0 expected 1", name);
    end
  endtask

  // Runs until one done pulse plus a few trailing cycles; returns the number of done pulses
  task automatic wait_done(input string name, output int nd);
    int tail = -1;
    nd = 0;
    for (int i = 0; i < 300 && tail != 0; i++) begin
      step();
      if (done) begin
        nd++;
        chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
        if (tail < 0) tail = 4;
      end
      if (tail > 0) tail--;
    end
  endtask

  task automatic run_frame(input int idx);
    int base;
    int nd;
    string nm;
    nm        = $sformatf("frame%0d", idx);
    base      = hs_n;
    auto_rsp  = 1'b1;
    m_axi.arready = 1'b1;
    start_frame(f[idx]);
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    wait_done(nm, nd);
    chk({nm, "_done_cnt"}, 64'(nd), 64'd1);
    chk({nm, "_bursts"}, 64'(hs_n - base), 64'(f[idx].n));
    for (int k = 0; k < f[idx].n; k++) begin
      chk($sformatf("%s_addr%0d", nm, k), log_a[base + k], exp_a[f[idx].first + k]);
      chk($sformatf("%s_len%0d", nm, k), 64'(log_l[base + k]), 64'(exp_l[f[idx].first + k]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int nd;
    bit any_valid;

    f[0] = '{1'b1, 64'h1000, 64'h8000, 64'h3000, 10'd1, 10'd1, 5, 0};
    set_exp(0, 64'h1000, 8'd5); set_exp(1, 64'h8000, 8'd2); set_exp(2, 64'h8180, 8'd2);
    set_exp(3, 64'hB000, 8'd2); set_exp(4, 64'hB180, 8'd2);
    f[1] = '{1'b0, 64'h0, 64'h100, 64'h1000, 10'd2, 10'd0, 3, 5};
    set_exp(5, 64'h100, 8'd2); set_exp(6, 64'h280, 8'd2); set_exp(7, 64'h400, 8'd2);
    f[2] = '{1'b0, 64'h0, 64'h4000, 64'h100, 10'd0, 10'd0, 1, 8};
    set_exp(8, 64'h4000, 8'd2);
    f[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FF00, 64'h200, 10'd1, 10'd1, 5, 9};
    set_exp(9, 64'hFFFF_FFFF_FFFF_FFF0, 8'd5); set_exp(10, 64'hFFFF_FFFF_FFFF_FF00, 8'd2);
    set_exp(11, 64'h80, 8'd2); set_exp(12, 64'h100, 8'd2); set_exp(13, 64'h280, 8'd2);
    f[4] = '{1'b0, 64'h0, 64'h10, 64'h40, 10'd0, 10'd2, 3, 14};
    set_exp(14, 64'h10, 8'd2); set_exp(15, 64'h50, 8'd2); set_exp(16, 64'h90, 8'd2);
    f[5] = '{1'b1, 64'hABC0, 64'h0, 64'h1000, 10'd2, 10'd1, 7, 17};
    set_exp(17, 64'hABC0, 8'd5); set_exp(18, 64'h0, 8'd2); set_exp(19, 64'h180, 8'd2);
    set_exp(20, 64'h300, 8'd2); set_exp(21, 64'h1000, 8'd2); set_exp(22, 64'h1180, 8'd2);
    set_exp(23, 64'h1300, 8'd2);
    f[6] = '{1'b0, 64'h0, 64'h500, 64'h100, 10'd0, 10'd0, 1, 24};
    set_exp(24, 64'h500, 8'd2);
    f[7] = '{1'b0, 64'h0, 64'h9000, 64'h100, 10'd0, 10'd0, 1, 25};
    set_exp(25, 64'h9000, 8'd2);

    m_axi.arready = 1'b0;
    rst = 1'b1;
    step(); step(); step();
    chk("rst_arvalid", 64'(m_axi.arvalid), 64'd0);
    chk("rst_araddr", m_axi.araddr, 64'd0);
    chk("rst_arlen", 64'(m_axi.arlen), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_frame(i);

    // Stall: request must hold steady while arready is low
    auto_rsp = 1'b1;
    m_axi.arready = 1'b0;
    base = hs_n;
    alt = '{1'b0, 64'h0, 64'h2000, 64'h800, 10'd1, 10'd0, 2, 0};
    start_frame(alt);
    wait_arvalid("stall_first");
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stall_valid%0d", i), 64'(m_axi.arvalid), 64'd1);
      chk($sformatf("stall_addr%0d", i), m_axi.araddr, 64'h2000);
      chk($sformatf("stall_len%0d", i), 64'(m_axi.arlen), 64'd2);
    end
    m_axi.arready = 1'b1;
    wait_done("stall", nd);
    chk("stall_done_cnt", 64'(nd), 64'd1);
    chk("stall_bursts", 64'(hs_n - base), 64'd2);
    chk("stall_addr_a", log_a[base], 64'h2000);
    chk("stall_addr_b", log_a[base + 1], 64'h2180);

    // rd_last_beat with nothing outstanding must not underflow
    auto_rsp = 1'b0;
    man_rd = 1'b1;
    step();
    man_rd = 1'b0;
    step();
    chk("idle_rd_cnt", 64'(dut.cnt_q), 64'd0);

    // Outstanding window and simultaneous handshake/rd_last_beat
    m_axi.arready = 1'b0;
    base = hs_n;
    alt = '{1'b0, 64'h0, 64'h0, 64'h1000, 10'd3, 10'd0, 4, 0};
    start_frame(alt);
    wait_arvalid("win_a");
    m_axi.arready = 1'b1;
    step();
    m_axi.arready = 1'b0;
    chk("win_hs1", 64'(hs_n - base), 64'd1);
    wait_arvalid("win_b");
    m_axi.arready = 1'b1;
    man_rd = 1'b1;
    step();
    m_axi.arready = 1'b0;
    man_rd = 1'b0;
    chk("same_cycle_cnt", 64'(dut.cnt_q), 64'd1);
    chk("win_hs2", 64'(hs_n - base), 64'd2);
    wait_arvalid("win_c");
    m_axi.arready = 1'b1;
    step();
    any_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (m_axi.arvalid) any_valid = 1'b1;
    end
    chk("win_limit_valid", 64'(any_valid), 64'd0);
    chk("win_limit_hs", 64'(hs_n - base), 64'd3);
    chk("win_limit_cnt", 64'(dut.cnt_q), 64'd2);
    man_rd = 1'b1;
    step();
    man_rd = 1'b0;
    wait_arvalid("win_d");
    step();
    chk("win_hs4", 64'(hs_n - base), 64'd4);
    chk("win_addr1", log_a[base + 1], 64'h180);
    chk("win_addr2", log_a[base + 2], 64'h300);
    chk("win_addr3", log_a[base + 3], 64'h480);
    step();
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_done", 64'(done), 64'd0);
    man_rd = 1'b1;
    step();
    man_rd = 1'b0;
    step();
    chk("drain_busy_one_left", 64'(busy), 64'd1);
    man_rd = 1'b1;
    step();
    man_rd = 1'b0;
    wait_done("win", nd);
    chk("win_done_cnt", 64'(nd), 64'd1);
    chk("win_total_hs", 64'(hs_n - base), 64'd4);

    // Reset in the middle of a macroblock request
    auto_rsp = 1'b1;
    m_axi.arready = 1'b0;
    alt = '{1'b0, 64'h0, 64'h40000, 64'h1000, 10'd3, 10'd3, 16, 0};
    start_frame(alt);
    wait_arvalid("mid_rst");
    chk("mid_rst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_arvalid", 64'(m_axi.arvalid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_araddr", m_axi.araddr, 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    step();
    run_frame(6);

    // A second start while busy is ignored
    m_axi.arready = 1'b0;
    auto_rsp = 1'b1;
    base = hs_n;
    start_frame(f[7]);
    alt = '{1'b1, 64'h6000, 64'h7000, 64'h100, 10'd3, 10'd3, 0, 0};
    start_frame(alt);
    chk("ignore_busy", 64'(busy), 64'd1);
    m_axi.arready = 1'b1;
    wait_done("ignore", nd);
    chk("ignore_done_cnt", 64'(nd), 64'd1);
    chk("ignore_bursts", 64'(hs_n - base), 64'd1);
    chk("ignore_addr", log_a[base], exp_a[25]);
    chk("ignore_len", 64'(log_l[base]), 64'(exp_l[25]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
